modport_reg: RTL and testbench

//  ID->EX pipeline register of the 5-stage CPU core. Captures the decoded

---
 rtl/modport_reg_if.sv | 57 +++++
 rtl/modport_reg.sv | 89 ++++++++
 tb/tb_modport_reg.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/modport_reg_if.sv
// Bundle carried across the ID->EX boundary, plus the stall/flush controls.
// The master side drives decode outputs; the slave side is the pipeline register.
interface modport_reg_if #(
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32,
    parameter int ALUOP_W  = 4,
    parameter int MEMOP_W  = 2,
    parameter int CTRLOP_W = 2,
    parameter int GPR_W    = 5,
    parameter int EXP_W    = 3
) ();
    logic                stall;
    logic                flush;
    logic [ADDR_W-1:0]   if_pc;
    logic                if_en;
    logic [ALUOP_W-1:0]  in_alu_op;
    logic [DATA_W-1:0]   in_alu_in_0;
    logic [DATA_W-1:0]   in_alu_in_1;
    logic                in_br_flag;
    logic [MEMOP_W-1:0]  in_mem_op;
    logic [DATA_W-1:0]   in_mem_wr_data;
    logic [CTRLOP_W-1:0] in_ctrl_op;
    logic [GPR_W-1:0]    in_dst_addr;
    logic                in_gpr_we_;
    logic [EXP_W-1:0]    in_exp_code;

    logic [ADDR_W-1:0]   id_pc;
    logic                id_en;
    logic [ALUOP_W-1:0]  out_alu_op;
    logic [DATA_W-1:0]   out_alu_in_0;
    logic [DATA_W-1:0]   out_alu_in_1;
    logic                out_br_flag;
    logic [MEMOP_W-1:0]  out_mem_op;
    logic [DATA_W-1:0]   out_mem_wr_data;
    logic [CTRLOP_W-1:0] out_ctrl_op;
    logic [GPR_W-1:0]    out_dst_addr;
    logic                out_gpr_we_;
    logic [EXP_W-1:0]    out_exp_code;

    modport master (
        output stall, flush, if_pc, if_en, in_alu_op, in_alu_in_0, in_alu_in_1,
               in_br_flag, in_mem_op, in_mem_wr_data, in_ctrl_op, in_dst_addr,
               in_gpr_we_, in_exp_code,
        input  id_pc, id_en, out_alu_op, out_alu_in_0, out_alu_in_1, out_br_flag,
               out_mem_op, out_mem_wr_data, out_ctrl_op, out_dst_addr,
               out_gpr_we_, out_exp_code
    );

    modport slave (
        input  stall, flush, if_pc, if_en, in_alu_op, in_alu_in_0, in_alu_in_1,
               in_br_flag, in_mem_op, in_mem_wr_data, in_ctrl_op, in_dst_addr,
               in_gpr_we_, in_exp_code,
        output id_pc, id_en, out_alu_op, out_alu_in_0, out_alu_in_1, out_br_flag,
               out_mem_op, out_mem_wr_data, out_ctrl_op, out_dst_addr,
               out_gpr_we_, out_exp_code
    );
endinterface

// File: rtl/modport_reg.sv
// ID->EX pipeline register: the whole bundle is one flop group so PC, valid
// and every field always move together. Reset and flush both load a NOP bubble.
module modport_reg #(
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32,
    parameter int ALUOP_W  = 4,
    parameter int MEMOP_W  = 2,
    parameter int CTRLOP_W = 2,
    parameter int GPR_W    = 5,
    parameter int EXP_W    = 3
) (
    input  logic         clk,
    input  logic         rst,
    modport_reg_if.slave bus
);
    typedef struct packed {
        logic [ADDR_W-1:0]   pc;
        logic                en;
        logic [ALUOP_W-1:0]  alu_op;
        logic [DATA_W-1:0]   alu_in_0;
        logic [DATA_W-1:0]   alu_in_1;
        logic                br_flag;
        logic [MEMOP_W-1:0]  mem_op;
        logic [DATA_W-1:0]   mem_wr_data;
        logic [CTRLOP_W-1:0] ctrl_op;
        logic [GPR_W-1:0]    dst_addr;
        logic                gpr_we_;
        logic [EXP_W-1:0]    exp_code;
    } stage_t;

    // All-zero bundle except the active-low write enable, which must read disabled.
    function automatic stage_t bubble_f();
        stage_t b;
        b         = {$bits(stage_t){1'b0}};
        b.gpr_we_ = 1'b1;
        return b;
    endfunction

    stage_t in_s;
    stage_t next_s;
    stage_t stage_r;

    assign in_s.pc          = bus.if_pc;
    assign in_s.en          = bus.if_en;
    assign in_s.alu_op      = bus.in_alu_op;
    assign in_s.alu_in_0    = bus.in_alu_in_0;
    assign in_s.alu_in_1    = bus.in_alu_in_1;
    assign in_s.br_flag     = bus.in_br_flag;
    assign in_s.mem_op      = bus.in_mem_op;
    assign in_s.mem_wr_data = bus.in_mem_wr_data;
    assign in_s.ctrl_op     = bus.in_ctrl_op;
    assign in_s.dst_addr    = bus.in_dst_addr;
    assign in_s.gpr_we_     = bus.in_gpr_we_;
    assign in_s.exp_code    = bus.in_exp_code;

    // Next-bundle select: stall wins over flush, flush over a normal load.
    always_comb begin
        next_s = stage_r;
        if (bus.stall) begin
            next_s = stage_r;
        end else if (bus.flush) begin
            next_s = bubble_f();
        end else begin
            next_s = in_s;
        end
    end

    // Stage register; reset overrides stall and flush on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_r <= bubble_f();
        end else begin
            stage_r <= next_s;
        end
    end

    assign bus.id_pc           = stage_r.pc;
    assign bus.id_en           = stage_r.en;
    assign bus.out_alu_op      = stage_r.alu_op;
    assign bus.out_alu_in_0    = stage_r.alu_in_0;
    assign bus.out_alu_in_1    = stage_r.alu_in_1;
    assign bus.out_br_flag     = stage_r.br_flag;
    assign bus.out_mem_op      = stage_r.mem_op;
    assign bus.out_mem_wr_data = stage_r.mem_wr_data;
    assign bus.out_ctrl_op     = stage_r.ctrl_op;
    assign bus.out_dst_addr    = stage_r.dst_addr;
    assign bus.out_gpr_we_     = stage_r.gpr_we_;
    assign bus.out_exp_code    = stage_r.exp_code;
endmodule

// File: tb/tb_modport_reg.sv
// Randomized bench for modport_reg: a bundle-level reference model tracks the
// expected register contents from the rst/stall/flush rules each edge.
module tb_modport_reg;
    localparam int BW = 145;
    // Bubble: everything zero except gpr_we_ (bit 3, just above the 3-bit exp_code).
    localparam logic [BW-1:0] BUBBLE = 145'd8;

    logic clk;
    logic rst;
    int   chk_cnt;
    int   pass_cnt;
    logic [BW-1:0] model_r;
    logic [BW-1:0] hist_q[$];

    modport_reg_if bus ();

    modport_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [BW-1:0] pack_in();
        return {bus.if_pc, bus.if_en, bus.in_alu_op, bus.in_alu_in_0, bus.in_alu_in_1,
                bus.in_br_flag, bus.in_mem_op, bus.in_mem_wr_data, bus.in_ctrl_op,
                bus.in_dst_addr, bus.in_gpr_we_, bus.in_exp_code};
    endfunction

    function automatic logic [BW-1:0] pack_out();
        return {bus.id_pc, bus.id_en, bus.out_alu_op, bus.out_alu_in_0, bus.out_alu_in_1,
                bus.out_br_flag, bus.out_mem_op, bus.out_mem_wr_data, bus.out_ctrl_op,
                bus.out_dst_addr, bus.out_gpr_we_, bus.out_exp_code};
    endfunction

    task automatic check_val(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic rand_inputs();
        bus.if_pc          = 30'($urandom);
        bus.if_en          = 1'($urandom);
        bus.in_alu_op      = 4'($urandom);
        bus.in_alu_in_0    = 32'($urandom);
        bus.in_alu_in_1    = 32'($urandom);
        bus.in_br_flag     = 1'($urandom);
        bus.in_mem_op      = 2'($urandom);
        bus.in_mem_wr_data = 32'($urandom);
        bus.in_ctrl_op     = 2'($urandom);
        bus.in_dst_addr    = 5'($urandom);
        bus.in_gpr_we_     = 1'($urandom);
        bus.in_exp_code    = 3'($urandom);
    endtask

    // Apply controls for one edge, advance the model, compare the whole bundle.
    task automatic cycle(input string tag, input logic r, input logic s, input logic f);
        rst       = r;
        bus.stall = s;
        bus.flush = f;
        @(posedge clk);
        if (r) begin
            model_r = BUBBLE;
        end else if (!s) begin
            model_r = f ? BUBBLE : pack_in();
        end
        #1;
        check_val(tag, pack_out(), model_r);
        @(negedge clk);
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        model_r  = BUBBLE;
        rst      = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        rand_inputs();
        bus.if_en      = 1'b1;
        bus.in_gpr_we_ = 1'b0;
        bus.in_exp_code = 3'd5;
        @(negedge clk);

        // 1: reset with non-zero inputs
        cycle("reset", 1'b1, 1'b0, 1'b0);
        check_val("reset_bubble", pack_out(), BUBBLE);
        check_val("reset_we", {144'd0, bus.out_gpr_we_}, 145'd1);

        // 2: directed load
        rand_inputs();
        bus.if_pc       = 30'h0000_0100;
        bus.if_en       = 1'b1;
        bus.in_alu_op   = 4'd3;
        bus.in_alu_in_0 = 32'hDEAD_BEEF;
        bus.in_dst_addr = 5'd7;
        bus.in_gpr_we_  = 1'b0;
        cycle("load", 1'b0, 1'b0, 1'b0);
        check_val("load_pc", {115'd0, bus.id_pc}, 145'h100);
        check_val("load_a0", {113'd0, bus.out_alu_in_0}, 145'hDEAD_BEEF);
        check_val("load_ctl", {136'd0, bus.id_en, bus.out_alu_op, bus.out_dst_addr},
                  {136'd0, 1'b1, 4'd3, 5'd7});

        // 3: stall three cycles with changing inputs, then release
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            cycle("stall_hold", 1'b0, 1'b1, 1'b0);
            check_val("stall_pc", {115'd0, bus.id_pc}, 145'h100);
        end
        rand_inputs();
        cycle("stall_release", 1'b0, 1'b0, 1'b0);
        check_val("release_cap", pack_out(), pack_in());

        // 4: flush with valid inputs
        rand_inputs();
        bus.if_en      = 1'b1;
        bus.in_gpr_we_ = 1'b0;
        bus.in_exp_code = 3'd6;
        cycle("flush", 1'b0, 1'b0, 1'b1);
        check_val("flush_fields", {140'd0, bus.id_en, bus.out_gpr_we_, bus.out_exp_code},
                  {140'd0, 1'b0, 1'b1, 3'd0});

        // 5: stall+flush holds a loaded bundle; reset during stall gives bubble
        rand_inputs();
        cycle("preload", 1'b0, 1'b0, 1'b0);
        rand_inputs();
        cycle("stall_flush_hold", 1'b0, 1'b1, 1'b1);
        check_val("stall_flush_not_bubble", {144'd0, pack_out() == BUBBLE}, 145'd0);
        rand_inputs();
        cycle("rst_in_stall", 1'b1, 1'b1, 1'b0);
        check_val("rst_in_stall_bubble", pack_out(), BUBBLE);

        // 6: back-to-back loads appear exactly one cycle after being applied
        hist_q.delete();
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            bus.if_pc = 30'(i + 16);
            hist_q.push_back(pack_in());
            cycle("b2b", 1'b0, 1'b0, 1'b0);
            check_val("b2b_seq", pack_out(), hist_q[i]);
        end

        // Random mix of reset, stall, flush and loads
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle("random", 1'(($urandom % 16) == 0), 1'(($urandom % 4) == 0),
                  1'(($urandom % 5) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
